// File: rtl/sd_audio_streamer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : sd_audio_streamer                                               |
// | Purpose  : Read sequencer between sd_controller and the audio sample FIFO. |
// |            Issues BLOCK_BYTES-sized reads from START_ADDR upward, forwards |
// |            each received byte into the FIFO, and only starts a new block   |
// |            once the FIFO can absorb a whole block.                         |
// | Revision : 1.0  initial release                                           |
// +----------------------------------------------------------------------------+
// | Ports                                                                      |
// |   clk_25mhz        in   clock shared with sd_controller and the FIFO       |
// |   reset            in   synchronous, active-high                           |
// |   play_in          in   1 = keep streaming, 0 = pause at block boundary    |
// |   sd_ready_in      in   sd_controller ready                                |
// |   sd_byte_in       in   sd_controller data byte                            |
// |   sd_byte_avail_in in   sd_controller byte_available (edge-detected)       |
// |   fifo_count_in    in   FIFO fill level in bytes                           |
// |   fifo_full_in     in   FIFO full                                          |
// |   sd_rd_out        out  read request, high for the whole ISSUE state       |
// |   sd_addr_out      out  block byte address, stable while a read runs      |
// |   fifo_din_out     out  byte to the FIFO                                  |
// |   fifo_wr_en_out   out  one-cycle FIFO write strobe                       |
// |   busy_out         out  high from ISSUE through WAIT_RDY                  |
// |   done_out         out  sticky end-of-range flag (non-looping build)      |
// |   ovf_err_out      out  sticky dropped-byte flag                          |
// |   blocks_out       out  completed block counter, wraps                    |
// +----------------------------------------------------------------------------+
// | Build option                                                               |
// |   SD_STREAM_LOOP_EN : when defined, the address wraps to START_ADDR at     |
// |                       END_ADDR and streaming continues forever; when       |
// |                       undefined, streaming stops and done_out is set.      |
// +----------------------------------------------------------------------------+
module sd_audio_streamer #(
   parameter logic [31:0] START_ADDR  = 32'h0000_0000,
   parameter logic [31:0] END_ADDR    = 32'h0010_0000,
   parameter int          BLOCK_BYTES = 512,
   parameter int          FIFO_DEPTH  = 1024,
   parameter int          CNT_W       = 11
) (
   input  logic             clk_25mhz,
   input  logic             reset,
   input  logic             play_in,
   input  logic             sd_ready_in,
   input  logic [7:0]       sd_byte_in,
   input  logic             sd_byte_avail_in,
   input  logic [CNT_W-1:0] fifo_count_in,
   input  logic             fifo_full_in,
   output logic             sd_rd_out,
   output logic [31:0]      sd_addr_out,
   output logic [7:0]       fifo_din_out,
   output logic             fifo_wr_en_out,
   output logic             busy_out,
   output logic             done_out,
   output logic             ovf_err_out,
   output logic [15:0]      blocks_out
);

   localparam int                BCNT_W       = $clog2(BLOCK_BYTES + 1);
   localparam logic [BCNT_W-1:0] c_block_cnt  = BCNT_W'(BLOCK_BYTES);
   localparam logic [CNT_W-1:0]  c_room_limit = CNT_W'(FIFO_DEPTH - BLOCK_BYTES);
   localparam logic [31:0]       c_addr_step  = 32'(BLOCK_BYTES);

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      ROOM     = 3'd1,
      ISSUE    = 3'd2,
      RECV     = 3'd3,
      WAIT_RDY = 3'd4
   } state_t;

   state_t            state_q, state_d;
   logic [BCNT_W-1:0] byte_cnt_q, byte_cnt_d;
   logic              avail_prev_q;
   logic              sd_rd_q, sd_rd_d;
   logic [31:0]       sd_addr_q, sd_addr_d;
   logic [7:0]        fifo_din_q, fifo_din_d;
   logic              fifo_wr_en_q, fifo_wr_en_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;
   logic              ovf_q, ovf_d;
   logic [15:0]       blocks_q, blocks_d;

   logic              byte_rise;
   logic              byte_window;
   logic [31:0]       next_addr;

   always_comb begin
      state_d      = state_q;
      byte_cnt_d   = byte_cnt_q;
      sd_addr_d    = sd_addr_q;
      fifo_din_d   = fifo_din_q;
      fifo_wr_en_d = 1'b0;
      done_d       = done_q;
      ovf_d        = ovf_q;
      blocks_d     = blocks_q;

      byte_rise = sd_byte_avail_in & ~avail_prev_q;
      next_addr = sd_addr_q + c_addr_step;

      // Bytes are accepted from the cycle the controller drops ready (so an
      // edge coinciding with ISSUE->RECV is not lost) until the block closes.
      // A rise in WAIT_RDY, or in RECV once the count is full, is an extra byte.
      byte_window = (state_q == RECV) || (state_q == WAIT_RDY) ||
                    ((state_q == ISSUE) && !sd_ready_in);

      if (byte_rise && byte_window) begin
         if (byte_cnt_q < c_block_cnt) begin
            // Dropped-on-full bytes still count so the block boundary stays put.
            byte_cnt_d = byte_cnt_q + 1'b1;
            if (fifo_full_in) begin
               ovf_d = 1'b1;
            end else begin
               fifo_wr_en_d = 1'b1;
               fifo_din_d   = sd_byte_in;
            end
         end else begin
            ovf_d = 1'b1;
         end
      end

      case (state_q)
         IDLE: begin
            if (play_in && !done_q && sd_ready_in) begin
               state_d = ROOM;
            end
         end
         ROOM: begin
            if (!play_in) begin
               state_d = IDLE;
            end else if (fifo_count_in <= c_room_limit) begin
               state_d = ISSUE;
            end
         end
         ISSUE: begin
            if (!sd_ready_in) begin
               state_d = RECV;
            end
         end
         RECV: begin
            if (byte_cnt_q == c_block_cnt) begin
               state_d = WAIT_RDY;
            end
         end
         WAIT_RDY: begin
            if (sd_ready_in) begin
               blocks_d   = blocks_q + 16'd1;
               byte_cnt_d = '0;
               if (next_addr >= END_ADDR) begin
`ifdef SD_STREAM_LOOP_EN
                  sd_addr_d = START_ADDR;
                  state_d   = ROOM;
`else
                  sd_addr_d = next_addr;
                  done_d    = 1'b1;
                  state_d   = IDLE;
`endif
               end else begin
                  sd_addr_d = next_addr;
                  state_d   = ROOM;
               end
            end
         end
         default: state_d = IDLE;
      endcase

      // Decoded from the next state so the registered outputs line up with state_q.
      sd_rd_d = (state_d == ISSUE);
      busy_d  = (state_d == ISSUE) || (state_d == RECV) || (state_d == WAIT_RDY);
   end

   always_ff @(posedge clk_25mhz) begin
      if (reset) begin
         state_q      <= IDLE;
         byte_cnt_q   <= '0;
         avail_prev_q <= 1'b0;
         sd_rd_q      <= 1'b0;
         sd_addr_q    <= START_ADDR;
         fifo_din_q   <= 8'h00;
         fifo_wr_en_q <= 1'b0;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
         ovf_q        <= 1'b0;
         blocks_q     <= 16'h0000;
      end else begin
         state_q      <= state_d;
         byte_cnt_q   <= byte_cnt_d;
         avail_prev_q <= sd_byte_avail_in;
         sd_rd_q      <= sd_rd_d;
         sd_addr_q    <= sd_addr_d;
         fifo_din_q   <= fifo_din_d;
         fifo_wr_en_q <= fifo_wr_en_d;
         busy_q       <= busy_d;
         done_q       <= done_d;
         ovf_q        <= ovf_d;
         blocks_q     <= blocks_d;
      end
   end

   assign sd_rd_out      = sd_rd_q;
   assign sd_addr_out    = sd_addr_q;
   assign fifo_din_out   = fifo_din_q;
   assign fifo_wr_en_out = fifo_wr_en_q;
   assign busy_out       = busy_q;
   assign done_out       = done_q;
   assign ovf_err_out    = ovf_q;
   assign blocks_out     = blocks_q;

endmodule
`default_nettype wire

// File: tb/tb_sd_audio_streamer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_sd_audio_streamer                                            |
// | Purpose  : Self-checking bench for sd_audio_streamer (END_ADDR = 0x400).   |
// |            Cycle vectors cover reset, backpressure and edge detection;     |
// |            a behavioural sd_controller then streams whole blocks.          |
// | Revision : 1.0  initial release                                           |
// +----------------------------------------------------------------------------+
module tb_sd_audio_streamer;

   logic        clk_25mhz = 1'b0;
   always #20 clk_25mhz = ~clk_25mhz;

   logic        reset;
   logic        play_in;
   logic        sd_ready_in;
   logic [7:0]  sd_byte_in;
   logic        sd_byte_avail_in;
   logic [10:0] fifo_count_in;
   logic        fifo_full_in;
   logic        sd_rd_out;
   logic [31:0] sd_addr_out;
   logic [7:0]  fifo_din_out;
   logic        fifo_wr_en_out;
   logic        busy_out;
   logic        done_out;
   logic        ovf_err_out;
   logic [15:0] blocks_out;

   sd_audio_streamer #(
      .END_ADDR (32'h0000_0400)
   ) dut (
      .clk_25mhz        (clk_25mhz),
      .reset            (reset),
      .play_in          (play_in),
      .sd_ready_in      (sd_ready_in),
      .sd_byte_in       (sd_byte_in),
      .sd_byte_avail_in (sd_byte_avail_in),
      .fifo_count_in    (fifo_count_in),
      .fifo_full_in     (fifo_full_in),
      .sd_rd_out        (sd_rd_out),
      .sd_addr_out      (sd_addr_out),
      .fifo_din_out     (fifo_din_out),
      .fifo_wr_en_out   (fifo_wr_en_out),
      .busy_out         (busy_out),
      .done_out         (done_out),
      .ovf_err_out      (ovf_err_out),
      .blocks_out       (blocks_out)
   );

   int n_chk  = 0;
   int n_fail = 0;

   // FIFO side: record every written byte; count read-request rising edges.
   logic [7:0] wq[$];
   int         rd_rises = 0;
   logic       rd_prev  = 1'b0;
   always @(negedge clk_25mhz) begin
      if (fifo_wr_en_out) wq.push_back(fifo_din_out);
      if (sd_rd_out && !rd_prev) rd_rises++;
      rd_prev = sd_rd_out;
   end

   typedef struct {
      bit          rst;
      bit          play;
      bit          rdy;
      bit          avail;
      logic [7:0]  b;
      logic [10:0] cnt;
      bit          full;
      bit          e_rd;
      bit          e_busy;
      bit          e_wr;
      logic [7:0]  e_din;
   } vec_t;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Expected FIFO contents: byte index[7:0], minus any bytes dropped on full.
   task automatic check_data(input string name, input int skip_from, input int skip_n);
      logic [7:0] exp_q[$];
      int         bad = 0;
      for (int i = 0; i < 512; i++) begin
         if (i < skip_from || i >= skip_from + skip_n) exp_q.push_back(8'(i));
      end
      chk({name, "_wr_count"}, 64'(wq.size()), 64'(exp_q.size()));
      for (int i = 0; i < exp_q.size() && i < wq.size(); i++) begin
         if (wq[i] !== exp_q[i]) bad++;
      end
      chk({name, "_data_errs"}, 64'(bad), 64'd0);
   endtask

   // Behavioural sd_controller: waits for rd, drops ready with the first byte,
   // then 512 byte_avail pulses (2 high, 6 low). Hooks at given byte indices
   // pause playback, assert FIFO full for 5 bytes, or assert reset and stop.
   task automatic serve_block(input int pause_at, input int full_at, input int reset_at,
                              output logic [31:0] rd_addr);
      int t = 0;
      rd_addr = 32'hFFFF_FFFF;
      while (!sd_rd_out && t < 200) begin
         @(negedge clk_25mhz);
         t++;
      end
      chk("rd_seen", 64'(sd_rd_out), 64'd1);
      if (!sd_rd_out) return;
      rd_addr = sd_addr_out;
      repeat (2) @(negedge clk_25mhz);
      for (int i = 0; i < 512; i++) begin
         if (i == pause_at)    play_in      = 1'b0;
         if (i == full_at)     fifo_full_in = 1'b1;
         if (i == full_at + 5) fifo_full_in = 1'b0;
         if (i == reset_at) begin
            reset            = 1'b1;
            sd_byte_avail_in = 1'b0;
            sd_ready_in      = 1'b1;
            fifo_full_in     = 1'b0;
            @(negedge clk_25mhz);
            return;
         end
         sd_byte_in       = 8'(i);
         sd_byte_avail_in = 1'b1;
         sd_ready_in      = 1'b0;
         repeat (2) @(negedge clk_25mhz);
         sd_byte_avail_in = 1'b0;
         repeat (6) @(negedge clk_25mhz);
      end
      sd_ready_in = 1'b1;
      @(negedge clk_25mhz);
   endtask

   initial begin
      vec_t        vecs[14];
      logic [31:0] a;

      reset = 1'b1; play_in = 1'b0; sd_ready_in = 1'b1; sd_byte_avail_in = 1'b0;
      sd_byte_in = 8'h00; fifo_count_in = 11'd0; fifo_full_in = 1'b0;

      //          rst play rdy  av  byte   cnt      full | rd busy wr din
      vecs[0]  = '{1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 11'd0,   1'b0, 1'b0, 1'b0, 1'b0, 8'h00};
      vecs[1]  = '{1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 11'd0,   1'b0, 1'b0, 1'b0, 1'b0, 8'h00};
      vecs[2]  = '{1'b0, 1'b1, 1'b1, 1'b0, 8'h00, 11'd513, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00};
      vecs[3]  = '{1'b0, 1'b1, 1'b1, 1'b0, 8'h00, 11'd513, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00};
      vecs[4]  = '{1'b0, 1'b1, 1'b1, 1'b0, 8'h00, 11'd513, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00};
      vecs[5]  = '{1'b0, 1'b1, 1'b1, 1'b0, 8'h00, 11'd512, 1'b0, 1'b1, 1'b1, 1'b0, 8'h00};
      vecs[6]  = '{1'b0, 1'b1, 1'b1, 1'b0, 8'h00, 11'd512, 1'b0, 1'b1, 1'b1, 1'b0, 8'h00};
      vecs[7]  = '{1'b0, 1'b1, 1'b0, 1'b1, 8'hA5, 11'd512, 1'b0, 1'b0, 1'b1, 1'b1, 8'hA5};
      vecs[8]  = '{1'b0, 1'b1, 1'b0, 1'b1, 8'hA5, 11'd512, 1'b0, 1'b0, 1'b1, 1'b0, 8'hA5};
      vecs[9]  = '{1'b0, 1'b1, 1'b0, 1'b0, 8'hA5, 11'd512, 1'b0, 1'b0, 1'b1, 1'b0, 8'hA5};
      vecs[10] = '{1'b0, 1'b1, 1'b0, 1'b1, 8'h3C, 11'd512, 1'b0, 1'b0, 1'b1, 1'b1, 8'h3C};
      vecs[11] = '{1'b0, 1'b1, 1'b0, 1'b0, 8'h3C, 11'd512, 1'b0, 1'b0, 1'b1, 1'b0, 8'h3C};
      vecs[12] = '{1'b1, 1'b1, 1'b0, 1'b1, 8'hFF, 11'd512, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00};
      vecs[13] = '{1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 11'd0,   1'b0, 1'b0, 1'b0, 1'b0, 8'h00};

      @(negedge clk_25mhz);
      for (int i = 0; i < 14; i++) begin
         reset            = vecs[i].rst;
         play_in          = vecs[i].play;
         sd_ready_in      = vecs[i].rdy;
         sd_byte_avail_in = vecs[i].avail;
         sd_byte_in       = vecs[i].b;
         fifo_count_in    = vecs[i].cnt;
         fifo_full_in     = vecs[i].full;
         @(negedge clk_25mhz);
         chk($sformatf("vec%0d_rd_busy_wr_din", i),
             64'({sd_rd_out, busy_out, fifo_wr_en_out, fifo_din_out}),
             64'({vecs[i].e_rd, vecs[i].e_busy, vecs[i].e_wr, vecs[i].e_din}));
      end
      chk("reset_addr_blocks_done_ovf",
          64'({sd_addr_out, blocks_out, done_out, ovf_err_out}), 64'd0);

      // Block 1 with a pause at byte 100: block still completes, then idles.
      wq.delete();
      rd_rises      = 0;
      play_in       = 1'b1;
      sd_ready_in   = 1'b1;
      fifo_count_in = 11'd0;
      serve_block(100, -100, -1, a);
      chk("blk1_rd_addr", 64'(a), 64'h0);
      check_data("blk1", 0, 0);
      chk("blk1_blocks", 64'(blocks_out), 64'd1);
      chk("blk1_addr", 64'(sd_addr_out), 64'h200);
      chk("blk1_busy", 64'(busy_out), 64'd0);
      chk("blk1_ovf", 64'(ovf_err_out), 64'd0);
      chk("blk1_one_rd", 64'(rd_rises), 64'd1);
      repeat (10) @(negedge clk_25mhz);
      chk("pause_no_new_rd", 64'(rd_rises), 64'd1);
      chk("pause_addr_held", 64'(sd_addr_out), 64'h200);

      // Resume; block 2 sees FIFO full for bytes 20..24 and reaches END_ADDR.
      play_in = 1'b1;
      wq.delete();
      serve_block(-1, 20, -1, a);
      chk("blk2_rd_addr", 64'(a), 64'h200);
      check_data("blk2", 20, 5);
      chk("blk2_ovf", 64'(ovf_err_out), 64'd1);
      chk("blk2_blocks", 64'(blocks_out), 64'd2);
`ifdef SD_STREAM_LOOP_EN
      chk("end_addr_wrapped", 64'(sd_addr_out), 64'h0);
      chk("end_done_clear", 64'(done_out), 64'd0);
      wq.delete();
      serve_block(-1, -100, 300, a);
      chk("wrap_rd_addr", 64'(a), 64'h0);
      chk("wrap_third_rd", 64'(rd_rises), 64'd3);
`else
      chk("end_addr_held", 64'(sd_addr_out), 64'h400);
      chk("end_done_set", 64'(done_out), 64'd1);
      repeat (20) @(negedge clk_25mhz);
      chk("end_no_new_rd", 64'(rd_rises), 64'd2);
      chk("end_busy", 64'(busy_out), 64'd0);
      chk("end_done_sticky", 64'(done_out), 64'd1);
      reset = 1'b1;
      @(negedge clk_25mhz);
      chk("reset_clears_done", 64'(done_out), 64'd0);
      reset = 1'b0;
      wq.delete();
      serve_block(-1, -100, 300, a);
      chk("restart_rd_addr", 64'(a), 64'h0);
`endif

      // Reset asserted at byte 300: everything back to reset values.
      chk("midblock_reset_outputs",
          64'({sd_rd_out, busy_out, fifo_wr_en_out, fifo_din_out, sd_addr_out,
               done_out, ovf_err_out, blocks_out}), 64'd0);
      reset = 1'b0;
      wq.delete();
      serve_block(-1, -100, -1, a);
      chk("after_reset_rd_addr", 64'(a), 64'h0);
      check_data("after_reset", 0, 0);
      chk("after_reset_blocks", 64'(blocks_out), 64'd1);
      chk("after_reset_addr", 64'(sd_addr_out), 64'h200);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
